// File: rtl/moore_11011_frame_tx.sv
// moore_11011_frame_tx
//   Serial frame transmitter for the 11011 sync-word link. Each word taken on
//   the valid/ready handshake goes out MSB first as one frame:
//   SYNC_LEN sync bits, DATA_W payload bits, then one guard bit at IDLE_BIT.
//   Every output is a register, so nothing passes combinationally from an
//   input to an output.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      payload word, sampled only on an accepted handshake
//   data_valid   payload word available
//   data_ready   block can take a word this cycle (IDLE or GUARD)
//   out          serial line
//   out_valid    a frame bit (sync, data or guard) is on out
//   sync_active  a sync bit is on out
//   busy         state is not IDLE
//   frame_done   guard-bit cycle of a frame
module moore_11011_frame_tx #(
    parameter int                  DATA_W    = 8,
    parameter int                  SYNC_LEN  = 5,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 5'b11011,
    parameter logic                IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out,
    output logic              out_valid,
    output logic              sync_active,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAXC  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GUARD} state_t;

    state_t              state, nxt_state;
    logic [CNT_W-1:0]    cnt, nxt_cnt;
    logic [DATA_W-1:0]   shreg, nxt_shreg;
    logic [SYNC_LEN-1:0] sync_sh;
    logic                accept;
    logic                nxt_out;

    // data_ready is a registered copy of (state is IDLE or GUARD), so it
    // doubles as the acceptance qualifier.
    assign accept = data_valid && data_ready;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_shreg = shreg;
        case (state)
            IDLE, GUARD: begin
                if (accept) begin
                    nxt_state = SYNC;
                    nxt_cnt   = '0;
                    nxt_shreg = data_in;
                end else begin
                    nxt_state = IDLE;
                end
            end
            SYNC: begin
                if (cnt == CNT_W'(SYNC_LEN - 1)) begin
                    nxt_state = DATA;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                nxt_shreg = shreg << 1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    nxt_state = GUARD;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they land in registers
        // aligned with the state they describe.
        sync_sh = SYNC_WORD << nxt_cnt;
        case (nxt_state)
            SYNC:    nxt_out = sync_sh[SYNC_LEN-1];
            DATA:    nxt_out = nxt_shreg[DATA_W-1];
            default: nxt_out = IDLE_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            out         <= IDLE_BIT;
            out_valid   <= 1'b0;
            sync_active <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            data_ready  <= 1'b1;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            shreg       <= nxt_shreg;
            out         <= nxt_out;
            out_valid   <= (nxt_state != IDLE);
            busy        <= (nxt_state != IDLE);
            sync_active <= (nxt_state == SYNC);
            frame_done  <= (nxt_state == GUARD);
            data_ready  <= (nxt_state == IDLE) || (nxt_state == GUARD);
        end
    end

endmodule
